// File: rtl/qvga_downscale_writer.sv
// qvga_downscale_writer: 2:1 x 2:1 box-filter downscaler that turns a SRC_W x SRC_H
//   RGB444 pixel stream into frame-buffer writes of DST_W x SRC_H/2 averaged pixels.
// Latency: one write strobe one cycle after each accepted odd-column/odd-row source pixel.
// Backpressure: none. The source cannot be stalled; in_valid gaps are tolerated anywhere.
//
// Ports:
//   clk        pixel clock
//   reset      asynchronous active-low reset
//   in_valid   source pixel present; in_sof / in_eol / in_data qualified by it
//   in_sof     first pixel of frame (restarts the frame from any state)
//   in_eol     last pixel of line
//   in_data    source pixel {R[3:0],G[3:0],B[3:0]}
//   qvga_we    one-cycle frame-buffer write strobe
//   qvga_addr  write address = dy*DST_W + dx
//   qvga_data  averaged pixel
//   frame_done one-cycle pulse with the write of the last address
//   line_err   sticky line-length error, cleared by in_sof or reset
//
// Build option: define DS_ROUND_EN for round-half-up averaging; default truncates.

module qvga_downscale_writer #(
  parameter int SRC_W = 640,
  parameter int SRC_H = 480,
  parameter int DST_W = 320
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic        in_eol,
  input  logic [11:0] in_data,
  output logic        qvga_we,
  output logic [16:0] qvga_addr,
  output logic [11:0] qvga_data,
  output logic        frame_done,
  output logic        line_err
);

  // sx must be able to hold SRC_W itself: that value marks "line overran".
  localparam int XW = $clog2(SRC_W + 1);
  localparam int YW = $clog2(SRC_H + 1);
  localparam int BW = $clog2(DST_W);
  localparam logic [16:0] LAST_ADDR = 17'(DST_W * SRC_H / 2 - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t         state_q, state_d;
  logic [XW-1:0]  sx_q, sx_d, px;
  logic [YW-1:0]  sy_q, sy_d, py;
  logic           err_d;
  logic           acc;      // pixel belongs to a frame being processed
  logic           proc;     // accepted pixel lies inside the source raster
  logic           wr;       // this pixel completes a 2x2 block
  logic [BW-1:0]  bidx;
  logic [11:0]    hreg;
  logic [14:0]    hp;       // horizontal pair sums, 5 bits per channel
  logic [14:0]    lb;       // pair sums of the previous (even) line
  logic [17:0]    s;        // block sums, 6 bits per channel
  logic [11:0]    avg;
  logic [16:0]    wr_addr;
  logic [14:0]    lbuf [DST_W];

  function automatic logic [3:0] scale(input logic [5:0] sum);
`ifdef DS_ROUND_EN
    logic [6:0] r;
    r = {1'b0, sum} + 7'd2;
    scale = (r[6:2] > 5'd15) ? 4'hF : r[5:2];
`else
    scale = 4'(sum >> 2);
`endif
  endfunction

  // A pixel carrying in_sof is always processed as position (0,0).
  assign acc  = in_valid && (in_sof || state_q == ACTIVE);
  assign px   = in_sof ? '0 : sx_q;
  assign py   = in_sof ? '0 : sy_q;
  assign proc = acc && (px < XW'(SRC_W)) && (py < YW'(SRC_H));
  assign wr   = proc && px[0] && py[0];
  assign bidx = px[BW:1];

  // Datapath: pair sum, block sum and per-channel average.
  always_comb begin
    hp      = '0;
    s       = '0;
    avg     = '0;
    lb      = lbuf[bidx];
    for (int c = 0; c < 3; c++) begin
      hp[c*5 +: 5]  = {1'b0, hreg[c*4 +: 4]} + {1'b0, in_data[c*4 +: 4]};
      s[c*6 +: 6]   = {1'b0, lb[c*5 +: 5]} + {1'b0, hp[c*5 +: 5]};
      avg[c*4 +: 4] = scale(s[c*6 +: 6]);
    end
    wr_addr = 17'(int'(py >> 1) * DST_W + int'(px >> 1));
  end

  // Frame FSM and raster counters.
  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    err_d   = line_err;
    if (acc) begin
      if (in_sof) begin
        // sof wins over a simultaneous eol: next pixel is still on line 0.
        state_d = ACTIVE;
        err_d   = 1'b0;
        sx_d    = in_eol ? '0 : XW'(1);
        sy_d    = '0;
      end else if (in_eol) begin
        if (sx_q != XW'(SRC_W - 1)) err_d = 1'b1;
        sx_d = '0;
        sy_d = (sy_q == YW'(SRC_H)) ? sy_q : sy_q + YW'(1);
      end else if (sx_q >= XW'(SRC_W)) begin
        err_d = 1'b1;   // overrun pixel is dropped, sx stays parked at SRC_W
      end else begin
        sx_d = sx_q + XW'(1);
      end
      if (proc && px == XW'(SRC_W - 1) && py == YW'(SRC_H - 1)) state_d = DONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sx_q       <= '0;
      sy_q       <= '0;
      line_err   <= 1'b0;
      hreg       <= '0;
      qvga_we    <= 1'b0;
      qvga_addr  <= '0;
      qvga_data  <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      line_err   <= err_d;
      qvga_we    <= wr;
      frame_done <= wr && (wr_addr == LAST_ADDR);
      if (proc && !px[0]) hreg <= in_data;
      if (wr) begin
        qvga_addr <= wr_addr;
        qvga_data <= avg;
      end
    end
  end

  // Line buffer carries no reset; it is always rewritten on an even line before use.
  always_ff @(posedge clk) begin
    if (proc && px[0] && !py[0]) lbuf[bidx] <= hp;
  end

endmodule

// File: tb/tb_qvga_downscale_writer.sv
module tb_qvga_downscale_writer;

  localparam int SRC_W = 128;
  localparam int SRC_H = 16;
  localparam int DST_W = 64;
  localparam int NBLK  = DST_W * SRC_H / 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic        in_eol = 1'b0;
  logic [11:0] in_data = '0;
  logic        qvga_we;
  logic [16:0] qvga_addr;
  logic [11:0] qvga_data;
  logic        frame_done;
  logic        line_err;

  always #5 clk = ~clk;

  qvga_downscale_writer #(.SRC_W(SRC_W), .SRC_H(SRC_H), .DST_W(DST_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_eol(in_eol),
    .in_data(in_data), .qvga_we(qvga_we), .qvga_addr(qvga_addr), .qvga_data(qvga_data),
    .frame_done(frame_done), .line_err(line_err)
  );

  typedef struct packed {
    logic [16:0] addr;
    logic [11:0] data;
    logic        done;
  } wr_t;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  wr_t exp_q[$];
  logic [11:0] img [SRC_H][SRC_W];
  logic [11:0] exp_blk [SRC_H/2][DST_W];

  // Scoreboard monitor: every write strobe must match the head of the queue.
  always @(negedge clk) begin
    if (qvga_we) begin
      wr_t e;
      wr_cnt++;
      if (frame_done) done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h", qvga_addr, qvga_data);
      end else begin
        e = exp_q.pop_front();
        if (qvga_addr !== e.addr || qvga_data !== e.data || frame_done !== e.done) begin
          errors++;
          $display("FAIL write got addr=%0d data=%h done=%b exp addr=%0d data=%h done=%b",
                   qvga_addr, qvga_data, frame_done, e.addr, e.data, e.done);
        end
      end
    end else if (frame_done) begin
      checks++;
      errors++;
      $display("FAIL frame_done_without_we got=1 exp=0");
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] avg_ch(input logic [3:0] a, b, c, d);
    int t;
    t = int'(a) + int'(b) + int'(c) + int'(d);
`ifdef DS_ROUND_EN
    t = (t + 2) / 4;
    if (t > 15) t = 15;
`else
    t = t / 4;
`endif
    return 4'(t);
  endfunction

  function automatic logic [11:0] avg4(input logic [11:0] a, b, c, d);
    return {avg_ch(a[11:8], b[11:8], c[11:8], d[11:8]),
            avg_ch(a[7:4],  b[7:4],  c[7:4],  d[7:4]),
            avg_ch(a[3:0],  b[3:0],  c[3:0],  d[3:0])};
  endfunction

  // Uniform frames: the average of four equal pixels is the pixel itself.
  task automatic fill(input int seed, input bit uniform, input logic [11:0] u);
    for (int y = 0; y < SRC_H; y++)
      for (int x = 0; x < SRC_W; x++)
        img[y][x] = uniform ? u : {4'(x + seed), 4'(y * 3 + seed), 4'(x ^ y)};
    for (int dy = 0; dy < SRC_H/2; dy++)
      for (int dx = 0; dx < DST_W; dx++)
        exp_blk[dy][dx] = uniform ? u :
          avg4(img[2*dy][2*dx], img[2*dy][2*dx+1], img[2*dy+1][2*dx], img[2*dy+1][2*dx+1]);
  endtask

  task automatic drive(input logic [11:0] d, input logic sof, input logic eol);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_sof = sof; in_eol = eol;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
  endtask

  task automatic run_frame(input bit gapped, input bit use_sof, input int short_y,
                           input int short_len, input int stop_x, input int stop_y,
                           input bit lat_chk);
    for (int y = 0; y < SRC_H; y++) begin
      int len;
      len = (y == short_y) ? short_len : SRC_W;
      for (int x = 0; x < len; x++) begin
        if ((x % 2 == 1) && (y % 2 == 1)) begin
          wr_t e;
          e.addr = 17'((y / 2) * DST_W + x / 2);
          e.data = exp_blk[y/2][x/2];
          e.done = (e.addr == 17'(NBLK - 1));
          exp_q.push_back(e);
        end
        drive(img[y][x], use_sof && x == 0 && y == 0, x == len - 1);
        if (x == stop_x && y == stop_y) return;
        if (lat_chk && x == 1 && y == 1) begin
          @(negedge clk); chk("lat_pre_we", qvga_we, 0);
          idle();
          @(negedge clk); chk("lat_we", qvga_we, 1);
          @(negedge clk); chk("lat_pulse_len", qvga_we, 0);
        end else if (gapped) begin
          idle();
        end
      end
    end
    idle();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_we", qvga_we, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", line_err, 0);
    chk("rst_addr", qvga_addr, 0);
    chk("rst_data", qvga_data, 0);
    @(posedge clk); #1 reset = 1'b1;

    // Frame 1: pattern with directed averaging and saturation blocks
    fill(1, 0, 12'h000);
    img[0][0] = 12'h000; img[0][1] = 12'h111; img[1][0] = 12'h222; img[1][1] = 12'h333;
    img[0][2] = 12'hFFF; img[0][3] = 12'hFFF; img[1][2] = 12'hFFF; img[1][3] = 12'hFFF;
    img[0][4] = 12'hFFF; img[0][5] = 12'hFFF; img[1][4] = 12'hFFF; img[1][5] = 12'hFFE;
    exp_blk[0][1] = 12'hFFF;
`ifdef DS_ROUND_EN
    exp_blk[0][0] = 12'h222;
    exp_blk[0][2] = 12'hFFF;
`else
    exp_blk[0][0] = 12'h111;
    exp_blk[0][2] = 12'hFFE;
`endif
    run_frame(0, 1, -1, 0, -1, -1, 1);
    chk("f1_writes", wr_cnt, NBLK);
    chk("f1_done_cnt", done_cnt, 1);
    chk("f1_q_empty", exp_q.size(), 0);
    chk("f1_line_err", line_err, 0);

    // DONE state ignores pixels without sof
    w0 = wr_cnt;
    for (int i = 0; i < 40; i++) drive(12'h777, 1'b0, (i % 16) == 15);
    idle(); repeat (3) @(posedge clk);
    chk("done_ignores", wr_cnt, w0);

    // sof+eol on one pixel restarts at (0,0); then a uniform frame without sof
    drive(12'h123, 1'b1, 1'b1);
    fill(0, 1, 12'hA5C);
    run_frame(0, 0, -1, 0, -1, -1, 0);
    chk("uni_writes", wr_cnt - w0, NBLK);
    chk("uni_done_cnt", done_cnt, 2);
    chk("uni_q_empty", exp_q.size(), 0);

    // Short line: eol at sx=100 on line 3
    fill(4, 0, 12'h000);
    run_frame(0, 1, 3, 101, -1, -1, 0);
    chk("short_line_err", line_err, 1);
    chk("short_done_cnt", done_cnt, 3);
    chk("short_q_empty", exp_q.size(), 0);
    drive(12'h000, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    chk("sof_clears_err", line_err, 0);

    // Gapped stream abandoned at (10,3) by a new sof, then a full gapped frame
    fill(2, 0, 12'h000);
    run_frame(1, 1, -1, 0, 9, 3, 0);
    fill(3, 0, 12'h000);
    run_frame(1, 1, -1, 0, -1, -1, 0);
    chk("gap_done_cnt", done_cnt, 4);
    chk("gap_q_empty", exp_q.size(), 0);
    chk("gap_line_err", line_err, 0);

    // Reset mid-frame while a write strobe and line_err are active
    fill(5, 0, 12'h000);
    run_frame(0, 1, 3, 101, 7, 7, 0);
    @(posedge clk); #1;
    chk("pre_rst_we", qvga_we, 1);
    chk("pre_rst_err", line_err, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_we", qvga_we, 0);
    chk("mid_rst_done", frame_done, 0);
    chk("mid_rst_err", line_err, 0);
    chk("mid_rst_addr", qvga_addr, 0);
    chk("mid_rst_data", qvga_data, 0);
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b1;
    w0 = wr_cnt;
    for (int i = 0; i < 30; i++) drive(12'h5A5, 1'b0, (i % 10) == 9);
    idle(); repeat (3) @(posedge clk);
    chk("idle_ignores", wr_cnt, w0);
    chk("idle_no_err", line_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
